edge_frame_scheduler: RTL
=========================

Name: edge_frame_scheduler

Overview:
- Sequences whole-frame operation of the AHB master controller for the edge-detection core.
- Walks the image window by window and issues one read request per 3-row window (column-aligned top pixel address).
- Tracks results returned by the edge core and arbitrates write-back requests against further reads.
- Generates read/write base addresses and end_of_image for the final write.

Parameters:
IMG_W, 8, image width in pixel words (>=3)
IMG_H, 6, image height in rows (>=3)
ADDR_W, 32, address width
RD_BASE, 32'h0000_0000, byte address of pixel (0,0) in the source image
WR_BASE, 32'h0001_0000, byte address of the first result word
MAX_PEND, 4, maximum reads issued but not yet written back (>=1)

Ports:
HCLK  in  1  system clock
HRESETn  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a frame when idle
rd_ack  in  1  pulse from controller addr_update_enable_r; current read window complete
wr_ack  in  1  pulse from controller shift_enable_w; current write data phase complete
result_valid  in  1  pulse from edge core; one result word ready for write-back
read_enable  out  1  read-window request to controller, level
write_enable  out  1  write request to controller, level
end_of_image  out  1  marks the final write of the frame
rd_addr  out  ADDR_W  byte address of the top pixel of the current window
wr_addr  out  ADDR_W  byte address for the current result word
busy  out  1  high from start acceptance until DONE
done  out  1  high in DONE
err_overflow  out  1  sticky; result_valid received with no read outstanding

Behaviour:
- Derived constants: WIN_W=IMG_W-2, WIN_H=IMG_H-2, TOTAL=WIN_W*WIN_H.
- Counters: col (0..WIN_W-1), row (0..WIN_H-1), rd_cnt and wr_cnt (0..TOTAL), pend (results held, 0..MAX_PEND).
- Outstanding: outst = rd_cnt - wr_cnt.
- Reset: all outputs 0. rd_addr=RD_BASE, wr_addr=WR_BASE, all counters 0, state IDLE.
- Reset mid-frame aborts immediately; no request stays asserted.
- States: IDLE, ARB, RD_WAIT, WR_WAIT, DONE.
- IDLE:
  - start -> clear counters, load base addresses, go to ARB.
  - busy rises in the cycle after start.
- ARB (one-cycle decision, registered):
  - If pend>0 -> WR_WAIT. Write has priority.
  - Else if rd_cnt<TOTAL and outst<MAX_PEND -> RD_WAIT.
  - Else if wr_cnt==TOTAL -> DONE.
  - Else stay in ARB, waiting for a result.
- RD_WAIT:
  - read_enable=1 held until rd_ack.
  - On rd_ack: rd_cnt++, then go to ARB (read_enable low the next cycle).
  - If col<WIN_W-1: col++, rd_addr+=4.
  - If col==WIN_W-1: col=0, row++, rd_addr+=12 (skips the two border columns).
- WR_WAIT:
  - write_enable=1 held until wr_ack.
  - end_of_image=1 while wr_cnt==TOTAL-1 (combinational from state and count).
  - On wr_ack: wr_cnt++, pend--, wr_addr+=4, go to ARB.
- DONE:
  - done=1, busy=0, outputs otherwise idle.
  - start -> same actions as from IDLE.
  - A new frame requires the controller to be reset; this is a system rule, not checked by this block.
- result_valid, accepted in any state except IDLE and DONE:
  - If outst>pend: pend++.
  - Otherwise: ignored and err_overflow set.
  - result_valid and wr_ack in the same cycle: pend unchanged.
- read_enable and write_enable are never high together.
- Acks arriving outside the matching wait state are ignored.
- start while busy is ignored.
- Counter widths: clog2(TOTAL+1) for rd_cnt/wr_cnt, clog2(MAX_PEND+1) for pend. Addresses wrap modulo 2^ADDR_W.

Test Plan:
- IMG_W=5, IMG_H=4 (TOTAL=6): start, then return rd_ack 3 cycles after each read_enable and result_valid 5 cycles after each rd_ack.
  - Required: 6 reads and 6 writes.
  - rd_addr sequence 0,4,8,20,24,28.
  - wr_addr sequence 0x10000..0x10014.
  - end_of_image only during the 6th write; done high afterwards.
- MAX_PEND=2 with result_valid withheld: exactly 2 reads issue, then ARB holds. The 3rd read issues only after the first result is written.
- result_valid and wr_ack in the same cycle while pend=1 -> pend remains 1 and a second write follows.
- result_valid with outst==0 -> err_overflow=1 and sticky. pend unchanged.
- HRESETn low while in WR_WAIT -> write_enable=0 immediately; after release, state IDLE with all counters 0. start is then accepted.
- start pulse during a frame -> counters and addresses unaffected. After DONE, a new start reruns the frame from RD_BASE.

Source files
------------

// File: rtl/edge_frame_scheduler.sv
// Frame sequencer for the edge-detection AHB master: walks the image one
// 3-row window at a time, issues a read per window, collects edge-core
// results and arbitrates their write-back against further reads.
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | waiting for start after reset
// S_ARB     | one-cycle decision: write first, then read, then finish
// S_RD_WAIT | read_enable held until the controller acks the window
// S_WR_WAIT | write_enable held until the controller acks the result
// S_DONE    | frame complete; start reruns the frame

module edge_frame_scheduler #(
   parameter int                IMG_W    = 8,
   parameter int                IMG_H    = 6,
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RD_BASE  = ADDR_W'(32'h0000_0000),
   parameter logic [ADDR_W-1:0] WR_BASE  = ADDR_W'(32'h0001_0000),
   parameter int                MAX_PEND = 4
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic              start,
   input  logic              rd_ack,
   input  logic              wr_ack,
   input  logic              result_valid,
   output logic              read_enable,
   output logic              write_enable,
   output logic              end_of_image,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              busy,
   output logic              done,
   output logic              err_overflow
);

   localparam int WIN_W  = IMG_W - 2;
   localparam int WIN_H  = IMG_H - 2;
   localparam int TOTAL  = WIN_W * WIN_H;
   localparam int CNT_W  = $clog2(TOTAL + 1);
   localparam int PEND_W = $clog2(MAX_PEND + 1);
   localparam int COL_W  = $clog2(WIN_W + 1);
   localparam int ROW_W  = $clog2(WIN_H + 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ARB     = 3'd1,
      S_RD_WAIT = 3'd2,
      S_WR_WAIT = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [COL_W-1:0]  col;
   logic [ROW_W-1:0]  row;
   logic [CNT_W-1:0]  rd_cnt;
   logic [CNT_W-1:0]  wr_cnt;
   logic [CNT_W-1:0]  outst;
   logic [PEND_W-1:0] pend;

   logic start_acc;
   logic res_in;
   logic res_ok;
   logic rd_done;
   logic wr_done;
   logic rd_more;
   logic rd_room;
   logic all_written;
   logic last_write;
   logic col_last;

   // Reads acked but not yet written back, so a result must match one of them.
   assign outst       = rd_cnt - wr_cnt;
   assign start_acc   = start && ((state == S_IDLE) || (state == S_DONE));
   assign res_in      = result_valid && (state != S_IDLE) && (state != S_DONE);
   assign res_ok      = 32'(outst) > 32'(pend);
   assign rd_done     = (state == S_RD_WAIT) && rd_ack;
   assign wr_done     = (state == S_WR_WAIT) && wr_ack;
   assign rd_more     = 32'(rd_cnt) < TOTAL;
   assign rd_room     = 32'(outst) < MAX_PEND;
   assign all_written = 32'(wr_cnt) == TOTAL;
   assign last_write  = 32'(wr_cnt) == (TOTAL - 1);
   assign col_last    = 32'(col) == (WIN_W - 1);

   // State register; async reset drops any pending request immediately.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decision; pending results win over new reads.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: begin
            if (start) state_nxt = S_ARB;
         end
         S_ARB: begin
            if (pend != '0)              state_nxt = S_WR_WAIT;
            else if (rd_more && rd_room) state_nxt = S_RD_WAIT;
            else if (all_written)        state_nxt = S_DONE;
         end
         S_RD_WAIT: begin
            if (rd_ack) state_nxt = S_ARB;
         end
         S_WR_WAIT: begin
            if (wr_ack) state_nxt = S_ARB;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs decoded from state only, so requests never overlap.
   always_comb begin
      read_enable  = 1'b0;
      write_enable = 1'b0;
      end_of_image = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      case (state)
         S_ARB:     busy = 1'b1;
         S_RD_WAIT: begin
            busy        = 1'b1;
            read_enable = 1'b1;
         end
         S_WR_WAIT: begin
            busy         = 1'b1;
            write_enable = 1'b1;
            end_of_image = last_write;
         end
         S_DONE:    done = 1'b1;
         default:   ;
      endcase
   end

   // Window walk: step one word per window, skip the two border words at row end.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         col     <= '0;
         row     <= '0;
         rd_cnt  <= '0;
         rd_addr <= RD_BASE;
      end else if (start_acc) begin
         col     <= '0;
         row     <= '0;
         rd_cnt  <= '0;
         rd_addr <= RD_BASE;
      end else if (rd_done) begin
         rd_cnt <= rd_cnt + CNT_W'(1);
         if (col_last) begin
            col     <= '0;
            row     <= row + ROW_W'(1);
            rd_addr <= rd_addr + ADDR_W'(12);
         end else begin
            col     <= col + COL_W'(1);
            rd_addr <= rd_addr + ADDR_W'(4);
         end
      end
   end

   // Write-back bookkeeping; a result arriving with a write ack nets to no change.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         wr_cnt       <= '0;
         wr_addr      <= WR_BASE;
         pend         <= '0;
         err_overflow <= 1'b0;
      end else if (start_acc) begin
         wr_cnt  <= '0;
         wr_addr <= WR_BASE;
         pend    <= '0;
      end else begin
         if (wr_done) begin
            wr_cnt  <= wr_cnt + CNT_W'(1);
            wr_addr <= wr_addr + ADDR_W'(4);
         end
         case ({res_in && res_ok, wr_done})
            2'b10:   pend <= pend + PEND_W'(1);
            2'b01:   pend <= pend - PEND_W'(1);
            default: pend <= pend;
         endcase
         if (res_in && !res_ok) err_overflow <= 1'b1;
      end
   end

endmodule
